// File: rtl/conv_seq_ctrl_if.sv
// Handshake and buffer-address bundle between the convolution sequencer and its datapath.
// The master side is the sequencer; the slave side is the buffers, MAC and result sink.
interface conv_seq_ctrl_if;
   logic       start;
   logic       abort;
   logic [9:0] data_addr;
   logic [7:0] weight_addr;
   logic       addr_valid;
   logic       mac_clr;
   logic       mac_en;
   logic       res_valid;
   logic       res_ready;
   logic [2:0] res_kernel;
   logic [4:0] res_row;
   logic [4:0] res_col;
   logic       busy;
   logic       done;

   modport master (
      input  start, abort, res_ready,
      output data_addr, weight_addr, addr_valid, mac_clr, mac_en,
      output res_valid, res_kernel, res_row, res_col, busy, done
   );

   modport slave (
      output start, abort, res_ready,
      input  data_addr, weight_addr, addr_valid, mac_clr, mac_en,
      input  res_valid, res_kernel, res_row, res_col, busy, done
   );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Sequencer for a valid-mode 2D convolution: walks kernels, output positions and kernel taps,
// issuing buffer reads and MAC control, and hands each finished output to a result sink.
module conv_seq_ctrl #(
   parameter int unsigned IMG_W       = 28,
   parameter int unsigned IMG_H       = 28,
   parameter int unsigned K           = 5,
   parameter int unsigned NUM_KERNELS = 8
) (
   input logic             clk,
   input logic             rst,
   conv_seq_ctrl_if.master bus
);

   localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StMac,
      StWait,
      StWrite,
      StDone
   } state_e;

   state_e        state_q;
   logic [KW-1:0] i_q;
   logic [KW-1:0] j_q;
   logic [2:0]    kernel_q;
   logic [4:0]    row_q;
   logic [4:0]    col_q;
   logic          mac_clr_q;
   logic          addr_valid_q;
   logic          mac_en_q;
   logic          res_valid_q;
   logic          busy_q;
   logic          done_q;

   logic j_last;
   logic ij_last;
   logic col_last;
   logic row_last;
   logic kernel_last;

   assign j_last      = (j_q == KW'(K - 1));
   assign ij_last     = j_last && (i_q == KW'(K - 1));
   assign col_last    = (col_q == 5'(IMG_W - K));
   assign row_last    = (row_q == 5'(IMG_H - K));
   assign kernel_last = (kernel_q == 3'(NUM_KERNELS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         i_q          <= '0;
         j_q          <= '0;
         kernel_q     <= '0;
         row_q        <= '0;
         col_q        <= '0;
         mac_clr_q    <= 1'b0;
         addr_valid_q <= 1'b0;
         mac_en_q     <= 1'b0;
         res_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         // Buffers return data one cycle after the address, so accumulate one cycle late.
         mac_en_q <= addr_valid_q;
         if (bus.abort) begin
            state_q      <= StIdle;
            i_q          <= '0;
            j_q          <= '0;
            kernel_q     <= '0;
            row_q        <= '0;
            col_q        <= '0;
            mac_clr_q    <= 1'b0;
            addr_valid_q <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (bus.start) begin
                     state_q   <= StClear;
                     mac_clr_q <= 1'b1;
                     busy_q    <= 1'b1;
                  end
               end
               StClear: begin
                  state_q      <= StMac;
                  mac_clr_q    <= 1'b0;
                  addr_valid_q <= 1'b1;
               end
               StMac: begin
                  if (ij_last) begin
                     state_q      <= StWait;
                     addr_valid_q <= 1'b0;
                     i_q          <= '0;
                     j_q          <= '0;
                  end else if (j_last) begin
                     i_q <= i_q + KW'(1);
                     j_q <= '0;
                  end else begin
                     j_q <= j_q + KW'(1);
                  end
               end
               StWait: begin
                  state_q     <= StWrite;
                  res_valid_q <= 1'b1;
               end
               StWrite: begin
                  if (bus.res_ready) begin
                     res_valid_q <= 1'b0;
                     if (kernel_last && row_last && col_last) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                     end else begin
                        state_q   <= StClear;
                        mac_clr_q <= 1'b1;
                        if (col_last) begin
                           col_q <= '0;
                           if (row_last) begin
                              row_q    <= '0;
                              kernel_q <= kernel_q + 3'd1;
                           end else begin
                              row_q <= row_q + 5'd1;
                           end
                        end else begin
                           col_q <= col_q + 5'd1;
                        end
                     end
                  end
               end
               StDone: begin
                  state_q  <= StIdle;
                  done_q   <= 1'b0;
                  busy_q   <= 1'b0;
                  kernel_q <= '0;
                  row_q    <= '0;
                  col_q    <= '0;
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   // Addresses are pure functions of the counters so they line up with addr_valid.
   assign bus.data_addr   = 10'((10'(row_q) + 10'(i_q)) * 10'(IMG_W) + 10'(col_q) + 10'(j_q));
   assign bus.weight_addr = 8'(8'(kernel_q) * 8'(K * K) + 8'(i_q) * 8'(K) + 8'(j_q));

   assign bus.addr_valid = addr_valid_q;
   assign bus.mac_clr    = mac_clr_q;
   assign bus.mac_en     = mac_en_q;
   assign bus.res_valid  = res_valid_q;
   assign bus.res_kernel = kernel_q;
   assign bus.res_row    = row_q;
   assign bus.res_col    = col_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl: expected reads and result tags are queued per run and
// popped by a negedge monitor; stimulus covers timing, backpressure, start-while-busy, abort, reset.
module tb_conv_seq_ctrl;

   localparam int W     = 7;
   localparam int H     = 6;
   localparam int KK    = 3;
   localparam int NK    = 2;
   localparam int NOUT  = NK * (H - KK + 1) * (W - KK + 1);
   localparam int PER   = KK * KK + 3;
   localparam int BOUND = NOUT * PER * 8 + 100;

   typedef struct {
      int d;
      int w;
   } rd_t;

   typedef struct {
      int k;
      int r;
      int c;
   } tag_t;

   logic clk;
   logic rst;

   conv_seq_ctrl_if bus ();

   conv_seq_ctrl #(
      .IMG_W       (W),
      .IMG_H       (H),
      .K           (KK),
      .NUM_KERNELS (NK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   vectors     = 0;
   int   miscompares = 0;
   rd_t  rd_q[$];
   tag_t tag_q[$];
   int   exp_done    = 0;
   logic prev_av     = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data_addr"},   32'(bus.data_addr),   0);
      check({tag, "_weight_addr"}, 32'(bus.weight_addr), 0);
      check({tag, "_addr_valid"},  32'(bus.addr_valid),  0);
      check({tag, "_mac_clr"},     32'(bus.mac_clr),     0);
      check({tag, "_mac_en"},      32'(bus.mac_en),      0);
      check({tag, "_res_valid"},   32'(bus.res_valid),   0);
      check({tag, "_res_kernel"},  32'(bus.res_kernel),  0);
      check({tag, "_res_row"},     32'(bus.res_row),     0);
      check({tag, "_res_col"},     32'(bus.res_col),     0);
      check({tag, "_busy"},        32'(bus.busy),        0);
      check({tag, "_done"},        32'(bus.done),        0);
   endtask

   // Reference model: a whole run as the list of taps and outputs in the documented order.
   task automatic push_run();
      for (int k = 0; k < NK; k++)
         for (int r = 0; r <= H - KK; r++)
            for (int c = 0; c <= W - KK; c++) begin
               for (int i = 0; i < KK; i++)
                  for (int j = 0; j < KK; j++)
                     rd_q.push_back('{d: (r + i) * W + c + j, w: k * KK * KK + i * KK + j});
               tag_q.push_back('{k: k, r: r, c: c});
            end
      exp_done++;
   endtask

   task automatic flush();
      rd_q.delete();
      tag_q.delete();
      exp_done = 0;
   endtask

   always @(negedge clk) begin : monitor
      rd_t  re;
      tag_t te;
      if (rst) begin
         prev_av = 1'b0;
      end else begin
         check("mac_en_delayed", 32'(bus.mac_en), 32'(prev_av));
         if (bus.addr_valid) begin
            if (rd_q.size() == 0) begin
               check("unexpected_read", 32'(bus.addr_valid), 0);
            end else begin
               re = rd_q.pop_front();
               check("data_addr", 32'(bus.data_addr), re.d);
               check("weight_addr", 32'(bus.weight_addr), re.w);
            end
         end
         if (bus.res_valid && bus.res_ready) begin
            if (tag_q.size() == 0) begin
               check("unexpected_result", 32'(bus.res_valid), 0);
            end else begin
               te = tag_q.pop_front();
               check("res_kernel", 32'(bus.res_kernel), te.k);
               check("res_row", 32'(bus.res_row), te.r);
               check("res_col", 32'(bus.res_col), te.c);
            end
         end
         if (bus.done) begin
            if (exp_done == 0) begin
               check("unexpected_done", 32'(bus.done), 0);
            end else begin
               exp_done--;
               check("reads_left_at_done", rd_q.size(), 0);
               check("results_left_at_done", tag_q.size(), 0);
            end
         end
         prev_av = bus.addr_valid;
      end
   end

   task automatic run(input bit rand_ready, input bit stall, input int kill_at, input bit kill_rst);
      int cyc      = 0;
      int done_cyc = 0;
      int clr_due  = 0;
      int hold     = 0;
      bit seen_done   = 1'b0;
      bit killed      = 1'b0;
      bit stalled     = 1'b0;
      bit release_now = 1'b0;
      @(posedge clk);
      #1;
      bus.res_ready = !stall;
      bus.start     = 1'b1;
      push_run();
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc = 1;
      while (!seen_done && !killed && cyc < BOUND) begin
         @(negedge clk);
         if (cyc == 1) check("clear_cycle1", 32'(bus.mac_clr), 1);
         if (cyc == 2) begin
            check("first_read_valid", 32'(bus.addr_valid), 1);
            check("first_data_addr", 32'(bus.data_addr), 0);
            check("first_weight_addr", 32'(bus.weight_addr), 0);
         end
         if (cyc == 3) check("first_mac_en", 32'(bus.mac_en), 1);
         if (cyc == PER) check("first_res_valid", 32'(bus.res_valid), 1);
         if (cyc == 5) bus.start = 1'b1;
         if (cyc == 6) bus.start = 1'b0;
         if (stall && !stalled && bus.res_valid) begin
            hold++;
            check("hold_res_valid", 32'(bus.res_valid), 1);
            check("hold_kernel", 32'(bus.res_kernel), 0);
            check("hold_row", 32'(bus.res_row), 0);
            check("hold_col", 32'(bus.res_col), 0);
            check("hold_addr_valid", 32'(bus.addr_valid), 0);
            check("hold_mac_en", 32'(bus.mac_en), 0);
            if (hold == 5) begin
               release_now = 1'b1;
               clr_due     = cyc + 2;
            end
         end
         if (clr_due != 0 && cyc == clr_due) check("clear_after_release", 32'(bus.mac_clr), 1);
         if (bus.done) begin
            seen_done = 1'b1;
            done_cyc  = cyc;
         end
         if (kill_at != 0 && cyc == kill_at) begin
            killed = 1'b1;
            if (kill_rst) begin
               rst = 1'b1;
               #1;
               check_all_zero("rst_mid");
               flush();
               @(posedge clk);
               #1;
               rst = 1'b0;
            end else begin
               bus.abort = 1'b1;
               @(posedge clk);
               #1;
               bus.abort = 1'b0;
               flush();
               check("abort_busy", 32'(bus.busy), 0);
               check("abort_addr_valid", 32'(bus.addr_valid), 0);
               check("abort_res_valid", 32'(bus.res_valid), 0);
               check("abort_data_addr", 32'(bus.data_addr), 0);
            end
         end else begin
            @(posedge clk);
            #1;
            if (release_now) begin
               bus.res_ready = 1'b1;
               release_now   = 1'b0;
               stalled       = 1'b1;
            end else if (rand_ready && (!stall || stalled)) begin
               bus.res_ready = ($urandom_range(0, 3) != 0);
            end
            cyc++;
         end
      end
      if (killed) begin
         repeat (15) begin
            @(negedge clk);
            check("no_done_after_kill", 32'(bus.done), 0);
            check("idle_after_kill", 32'(bus.busy), 0);
         end
      end else begin
         check("run_completed", 32'(seen_done), 1);
         if (!rand_ready && !stall) check("done_cycle", done_cyc, NOUT * PER + 1);
         repeat (10) begin
            @(negedge clk);
            check("busy_after_done", 32'(bus.busy), 0);
            check("no_second_run", 32'(bus.addr_valid), 0);
         end
      end
      bus.res_ready = 1'b1;
   endtask

   initial begin
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.res_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      run(1'b0, 1'b0, 0, 1'b0);
      run(1'b1, 1'b1, 0, 1'b0);
      run(1'b0, 1'b0, 100, 1'b0);
      run(1'b0, 1'b0, 0, 1'b0);
      run(1'b0, 1'b0, 40, 1'b1);
      run(1'b0, 1'b0, 0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
